// File: rtl/grip_ctrl.sv
// Gripper hand controller: debounced dual-gauge contact sensing, close/hold/open
// sequencing with a closing timeout, and a fixed-period PWM motor drive.
module grip_ctrl #(
    parameter int PWM_PERIOD = 100,
    parameter int DUTY_CLOSE = 60,
    parameter int DUTY_OPEN  = 40,
    parameter int DEBOUNCE   = 4,
    parameter int TIMEOUT    = 1000,
    parameter int OPEN_TIME  = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_limit1,
    input  logic       i_limit2,
    input  logic       i_grip_cmd,
    input  logic       i_release_cmd,
    output logic       o_pwm,
    output logic       o_dir,
    output logic       o_busy,
    output logic       o_fault,
    output logic [2:0] o_state
);

    localparam int TMAX = (TIMEOUT > OPEN_TIME) ? TIMEOUT : OPEN_TIME;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int PW   = (PWM_PERIOD > 2) ? $clog2(PWM_PERIOD) : 1;
    localparam int DW   = $clog2(DEBOUNCE + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLOSING = 3'd1,
        HOLD    = 3'd2,
        OPENING = 3'd3,
        FAULT   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [PW-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic [DW-1:0]   deb1_q, deb1_d, deb2_q, deb2_d;
    logic            pwm_q, pwm_d;
    logic            dir_q, dir_d;
    logic            busy_q, busy_d;
    logic            fault_q, fault_d;
    logic            contact;

    function automatic logic [DW-1:0] deb_next(input logic in, input logic [DW-1:0] cnt);
        if (!in)
            return '0;
        if (cnt == DW'(DEBOUNCE))
            return cnt;
        return cnt + DW'(1);
    endfunction

    assign contact = (deb1_q == DW'(DEBOUNCE)) && (deb2_q == DW'(DEBOUNCE));

    always_comb begin
        deb1_d  = deb_next(i_limit1, deb1_q);
        deb2_d  = deb_next(i_limit2, deb2_q);

        state_d = state_q;
        case (state_q)
            IDLE:    if (!i_release_cmd && i_grip_cmd) state_d = CLOSING;
            CLOSING: begin
                if (i_release_cmd)                      state_d = OPENING;
                else if (contact)                       state_d = HOLD;
                else if (timer_q == TW'(TIMEOUT - 1))   state_d = FAULT;
            end
            HOLD: begin
                if (i_release_cmd)                      state_d = OPENING;
                else if (!contact)                      state_d = CLOSING;
            end
            OPENING: if (timer_q == TW'(OPEN_TIME - 1)) state_d = IDLE;
            FAULT:   if (i_release_cmd)                 state_d = OPENING;
            default:                                    state_d = IDLE;
        endcase

        // Timer and PWM phase both restart whenever the state changes
        timer_d   = timer_q;
        pwm_cnt_d = '0;
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (state_q == CLOSING || state_q == OPENING) begin
            if (timer_q != '1)
                timer_d = timer_q + TW'(1);
            if (pwm_cnt_q != PW'(PWM_PERIOD - 1))
                pwm_cnt_d = pwm_cnt_q + PW'(1);
        end

        pwm_d = 1'b0;
        if (state_d == CLOSING)
            pwm_d = 32'(pwm_cnt_d) < 32'(DUTY_CLOSE);
        else if (state_d == OPENING)
            pwm_d = 32'(pwm_cnt_d) < 32'(DUTY_OPEN);
        dir_d   = (state_d == CLOSING) || (state_d == HOLD);
        busy_d  = (state_d == CLOSING) || (state_d == OPENING);
        fault_d = (state_d == FAULT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            pwm_cnt_q <= '0;
            deb1_q    <= '0;
            deb2_q    <= '0;
            pwm_q     <= 1'b0;
            dir_q     <= 1'b0;
            busy_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pwm_cnt_q <= pwm_cnt_d;
            deb1_q    <= deb1_d;
            deb2_q    <= deb2_d;
            pwm_q     <= pwm_d;
            dir_q     <= dir_d;
            busy_q    <= busy_d;
            fault_q   <= fault_d;
        end
    end

    assign o_state = state_q;
    assign o_pwm   = pwm_q;
    assign o_dir   = dir_q;
    assign o_busy  = busy_q;
    assign o_fault = fault_q;

endmodule

// File: tb/tb_grip_ctrl.sv
// Self-checking bench for grip_ctrl: a vector table for reset/close/hold plus
// hand-written sequences for re-grip, opening, timeout and priority corners.
module tb_grip_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_limit1 = 1'b0, i_limit2 = 1'b0, i_grip_cmd = 1'b0, i_release_cmd = 1'b0;
    logic       o_pwm, o_dir, o_busy, o_fault;
    logic [2:0] o_state;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct {
        logic       rst, l1, l2, grip, rel;
        logic [2:0] st;
        logic       pwm;
        string      name;
    } vec_t;

    vec_t vecs[$];

    grip_ctrl #(
        .PWM_PERIOD(10), .DUTY_CLOSE(6), .DUTY_OPEN(4),
        .DEBOUNCE(4), .TIMEOUT(50), .OPEN_TIME(20)
    ) dut (
        .clk(clk), .rst(rst),
        .i_limit1(i_limit1), .i_limit2(i_limit2),
        .i_grip_cmd(i_grip_cmd), .i_release_cmd(i_release_cmd),
        .o_pwm(o_pwm), .o_dir(o_dir), .o_busy(o_busy),
        .o_fault(o_fault), .o_state(o_state)
    );

    always #5 clk = ~clk;

    // Drive inputs, let one rising edge sample them, then settle just after it
    task automatic applyStimulus(input logic r, input logic a, input logic b,
                                 input logic g, input logic rl);
        rst           = r;
        i_limit1      = a;
        i_limit2      = b;
        i_grip_cmd    = g;
        i_release_cmd = rl;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [2:0] st, input logic pwm);
        logic dir, busy, fault;
        dir   = (st == 3'd1) || (st == 3'd2);
        busy  = (st == 3'd1) || (st == 3'd3);
        fault = (st == 3'd4);
        n_compared++;
        if ({o_state, o_pwm, o_dir, o_busy, o_fault} !== {st, pwm, dir, busy, fault}) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got state=%0d pwm=%b dir=%b busy=%b fault=%b, want state=%0d pwm=%b dir=%b busy=%b fault=%b",
                     name, o_state, o_pwm, o_dir, o_busy, o_fault, st, pwm, dir, busy, fault);
        end
    endtask

    task automatic doReset();
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
    endtask

    function automatic void add(input logic r, input logic a, input logic b, input logic g,
                                input logic rl, input logic [2:0] st, input logic pwm,
                                input string nm);
        vec_t v;
        v.rst = r; v.l1 = a; v.l2 = b; v.grip = g; v.rel = rl;
        v.st = st; v.pwm = pwm; v.name = nm;
        vecs.push_back(v);
    endfunction

    initial begin
        logic lim;

        // Reset with every input high, then a grip; a 3-sample glitch on both
        // limits must not reach HOLD, a steady pair from cycle 10 must
        add(1, 1, 1, 1, 1, 3'd0, 1'b0, "reset_1");
        add(1, 1, 1, 1, 1, 3'd0, 1'b0, "reset_2");
        add(0, 0, 0, 1, 0, 3'd1, 1'b1, "enter_closing");
        for (int c = 1; c <= 13; c++) begin
            lim = ((c >= 3) && (c <= 5)) || (c >= 10);
            add(0, lim, lim, 0, 0, 3'd1, (c % 10) < 6, $sformatf("closing_c%0d", c));
        end
        add(0, 1, 1, 0, 0, 3'd2, 1'b0, "hold_entry");
        add(0, 1, 1, 0, 0, 3'd2, 1'b0, "hold_stay");

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].l1, vecs[i].l2, vecs[i].grip, vecs[i].rel);
            checkOutput(vecs[i].name, vecs[i].st, vecs[i].pwm);
        end

        // Re-grip: limit2 low for one sample
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("regrip_drop_sampled", 3'd2, 1'b0);
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("regrip_closing", 3'd1, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(0, 1, 1, 0, 0);
            checkOutput($sformatf("regrip_c%0d", k), 3'd1, 1'b1);
        end
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("regrip_hold", 3'd2, 1'b0);

        // Release from HOLD with grip held throughout
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("open_entry", 3'd3, 1'b1);
        for (int k = 1; k <= 19; k++) begin
            applyStimulus(0, 0, 0, 1, 0);
            checkOutput($sformatf("open_k%0d", k), 3'd3, (k % 10) < 4);
        end
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("open_done_idle", 3'd0, 1'b0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("grip_after_open", 3'd1, 1'b1);

        // Timeout into FAULT
        doReset();
        checkOutput("reset_mid_closing", 3'd0, 1'b0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("to_enter", 3'd1, 1'b1);
        for (int c = 1; c <= 49; c++) begin
            applyStimulus(0, 0, 0, 0, 0);
            checkOutput($sformatf("to_c%0d", c), 3'd1, (c % 10) < 6);
        end
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("timeout_fault", 3'd4, 1'b0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("fault_ignores_grip", 3'd4, 1'b0);
        applyStimulus(1, 1, 1, 1, 1);
        checkOutput("reset_in_fault", 3'd0, 1'b0);

        // Release out of FAULT
        doReset();
        applyStimulus(0, 0, 0, 1, 0);
        for (int c = 1; c <= 50; c++)
            applyStimulus(0, 0, 0, 0, 0);
        checkOutput("fault_again", 3'd4, 1'b0);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("fault_release", 3'd3, 1'b1);

        // Contact completing on the final CLOSING cycle wins over the fault
        doReset();
        applyStimulus(0, 0, 0, 1, 0);
        for (int c = 1; c <= 45; c++)
            applyStimulus(0, 0, 0, 0, 0);
        for (int c = 46; c <= 49; c++) begin
            applyStimulus(0, 1, 1, 0, 0);
            checkOutput($sformatf("late_c%0d", c), 3'd1, (c % 10) < 6);
        end
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("contact_on_last", 3'd2, 1'b0);

        // Release priority over grip
        doReset();
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("both_idle_1", 3'd0, 1'b0);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("both_idle_2", 3'd0, 1'b0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("grip_idle", 3'd1, 1'b1);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("both_closing", 3'd3, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
